// File: rtl/cpa_share_arbiter.sv
`default_nettype none
// ============================================================================
// cpa_share_arbiter - one combinational CPA shared among N_REQ requesters,
// with an operand stage and a result stage. Option macro: CPA_ARB_PRIO_EN.
// Revision: 1.0
// ============================================================================

module CPA_module #(
  parameter int BITS = 40
) (
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  output logic [BITS-1:0] sum
);
  assign sum = a + b;
endmodule

module cpa_share_arbiter #(
  parameter  int BITS  = 40,
  parameter  int N_REQ = 4,
  localparam int IDW   = $clog2(N_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [N_REQ*BITS-1:0] req_a,
  input  logic [N_REQ*BITS-1:0] req_b,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [BITS-1:0]       res_sum,
  output logic [IDW-1:0]        res_id,
  output logic                  busy
);

`ifdef CPA_ARB_PRIO_EN
  localparam int RR_SPAN = N_REQ - 1;
`else
  localparam int RR_SPAN = N_REQ;
`endif
  localparam logic [IDW-1:0] PTR_RST = IDW'(N_REQ - 1);

  logic            s1_valid_q, s1_valid_d;
  logic [BITS-1:0] s1_a_q, s1_a_d;
  logic [BITS-1:0] s1_b_q, s1_b_d;
  logic [IDW-1:0]  s1_id_q, s1_id_d;
  logic            s2_valid_q, s2_valid_d;
  logic [BITS-1:0] s2_sum_q, s2_sum_d;
  logic [IDW-1:0]  s2_id_q, s2_id_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;

  logic            s1_en;
  logic            s2_en;
  logic            grant_found;
  logic [IDW-1:0]  grant_idx;
  logic            xfer;
  logic [BITS-1:0] sel_a;
  logic [BITS-1:0] sel_b;
  logic [BITS-1:0] cpa_sum;

  // k-th candidate after ptr; with priority the ring excludes requester 0
  function automatic logic [IDW-1:0] rr_cand(input logic [IDW-1:0] ptr, input int k);
`ifdef CPA_ARB_PRIO_EN
    return IDW'(((int'(ptr) - 1 + k) % RR_SPAN) + 1);
`else
    return IDW'((int'(ptr) + k) % RR_SPAN);
`endif
  endfunction

  assign s2_en = !s2_valid_q || res_ready;
  assign s1_en = !s1_valid_q || s2_en;

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
`ifdef CPA_ARB_PRIO_EN
    if (req_valid[0]) grant_found = 1'b1;
`endif
    for (int k = 1; k <= RR_SPAN; k++) begin
      if (!grant_found && req_valid[rr_cand(rr_ptr_q, k)]) begin
        grant_found = 1'b1;
        grant_idx   = rr_cand(rr_ptr_q, k);
      end
    end
  end

  assign req_ready = (s1_en && grant_found && !rst) ? (N_REQ'(1) << grant_idx) : '0;
  assign xfer      = |(req_valid & req_ready);
  assign sel_a     = req_a[int'(grant_idx)*BITS +: BITS];
  assign sel_b     = req_b[int'(grant_idx)*BITS +: BITS];

  CPA_module #(
    .BITS(BITS)
  ) u_cpa (
    .a  (s1_a_q),
    .b  (s1_b_q),
    .sum(cpa_sum)
  );

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_id_d    = s1_id_q;
    s2_valid_d = s2_valid_q;
    s2_sum_d   = s2_sum_q;
    s2_id_d    = s2_id_q;
    rr_ptr_d   = rr_ptr_q;
    if (s1_en) s1_valid_d = xfer;
    if (xfer) begin
      s1_a_d  = sel_a;
      s1_b_d  = sel_b;
      s1_id_d = grant_idx;
`ifdef CPA_ARB_PRIO_EN
      if (grant_idx != '0) rr_ptr_d = grant_idx;
`else
      rr_ptr_d = grant_idx;
`endif
    end
    if (s2_en) begin
      s2_valid_d = s1_valid_q;
      s2_sum_d   = cpa_sum;
      s2_id_d    = s1_id_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_id_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_sum_q   <= '0;
      s2_id_q    <= '0;
      rr_ptr_q   <= PTR_RST;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_id_q    <= s1_id_d;
      s2_valid_q <= s2_valid_d;
      s2_sum_q   <= s2_sum_d;
      s2_id_q    <= s2_id_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  assign res_valid = s2_valid_q;
  assign res_sum   = s2_sum_q;
  assign res_id    = s2_id_q;
  assign busy      = s1_valid_q || s2_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_cpa_share_arbiter.sv
`default_nettype none
// ============================================================================
// tb_cpa_share_arbiter - scoreboard bench for cpa_share_arbiter (4 x 40-bit).
// Revision: 1.0
// ============================================================================
module tb_cpa_share_arbiter;
  localparam int BITS = 40;
  localparam int N    = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*BITS-1:0] req_a;
  logic [N*BITS-1:0] req_b;
  logic              res_valid;
  logic              res_ready;
  logic [BITS-1:0]   res_sum;
  logic [IDW-1:0]    res_id;
  logic              busy;

  cpa_share_arbiter #(.BITS(BITS), .N_REQ(N)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_sum(res_sum), .res_id(res_id), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [BITS-1:0] sum;
    logic [IDW-1:0]  id;
  } exp_t;

  exp_t         sb[$];
  int           out_ids[$];
  int           n_checks = 0;
  int           n_fail = 0;
  logic         m_s1v = 1'b0;
  logic         m_s2v = 1'b0;
  int           m_rr = N - 1;
  logic         last_xfer = 1'b0;
  int           last_gid = 0;
  int           xfer_count = 0;
  logic [N-1:0] refill = '0;
  logic         rand_mode = 1'b0;
  int           wait_x[N];

  function automatic int model_grant(input logic [N-1:0] v, input int ptr);
    int i;
    i = ptr;
`ifdef CPA_ARB_PRIO_EN
    if (v[0]) return 0;
    for (int k = 0; k < N - 1; k++) begin
      i = (i >= N - 1) ? 1 : i + 1;
      if (v[i]) return i;
    end
`else
    for (int k = 0; k < N; k++) begin
      i = (i + 1) % N;
      if (v[i]) return i;
    end
`endif
    return -1;
  endfunction

  // Reference model evaluated mid-cycle; state becomes post-edge state
  always @(negedge clk) begin
    int           g;
    logic [N-1:0] exp_ready;
    logic         s1en;
    logic         s2en;
    exp_t         e;
    if (rst) begin
      n_checks++;
      if (req_ready !== '0) begin
        n_fail++;
        $display("FAIL ready_in_reset: req_ready=%b required=0000", req_ready);
      end
      m_s1v = 1'b0; m_s2v = 1'b0; m_rr = N - 1; last_xfer = 1'b0;
      sb.delete();
      foreach (wait_x[i]) wait_x[i] = 0;
    end else begin
      s2en = !m_s2v || res_ready;
      s1en = !m_s1v || s2en;
      g = s1en ? model_grant(req_valid, m_rr) : -1;
      exp_ready = (g >= 0) ? (N'(1) << g) : '0;
      n_checks++;
      if (req_ready !== exp_ready) begin
        n_fail++;
        $display("FAIL grant @%0t: req_ready=%b required=%b", $time, req_ready, exp_ready);
      end
      n_checks++;
      if (res_valid !== m_s2v || busy !== (m_s1v || m_s2v)) begin
        n_fail++;
        $display("FAIL valid_busy @%0t: res_valid=%b busy=%b required %b %b",
                 $time, res_valid, busy, m_s2v, m_s1v || m_s2v);
      end
      if (m_s2v) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL scoreboard_empty @%0t: res_sum=%h res_id=%0d required none", $time, res_sum, res_id);
        end else if (res_sum !== sb[0].sum || res_id !== sb[0].id) begin
          n_fail++;
          $display("FAIL result @%0t: sum=%h id=%0d required sum=%h id=%0d",
                   $time, res_sum, res_id, sb[0].sum, sb[0].id);
        end
        if (res_ready) begin
          out_ids.push_back(int'(res_id));
          if (sb.size() > 0) void'(sb.pop_front());
        end
      end
      last_xfer = (g >= 0);
      if (last_xfer) begin
        e.sum = req_a[g*BITS +: BITS] + req_b[g*BITS +: BITS];
        e.id  = IDW'(g);
        sb.push_back(e);
        last_gid = g;
        xfer_count++;
`ifndef CPA_ARB_PRIO_EN
        n_checks++;
        if (wait_x[g] > N - 1) begin
          n_fail++;
          $display("FAIL starvation: requester %0d waited %0d transfers required <=%0d", g, wait_x[g], N - 1);
        end
        for (int i = 0; i < N; i++) if (i != g && req_valid[i]) wait_x[i]++;
        wait_x[g] = 0;
        m_rr = g;
`else
        if (g != 0) m_rr = g;
`endif
      end
      if (s2en) m_s2v = m_s1v;
      if (s1en) m_s1v = last_xfer;
    end
  end

  function automatic logic [BITS-1:0] rand_op();
    if ($urandom_range(0, 7) == 0) return {BITS{1'b1}};
    return BITS'({$urandom(), $urandom()});
  endfunction

  task automatic load_op(input int i, input logic [BITS-1:0] a, input logic [BITS-1:0] b);
    req_a[i*BITS +: BITS] = a;
    req_b[i*BITS +: BITS] = b;
    req_valid[i] = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (last_xfer) begin
      if (refill[last_gid]) load_op(last_gid, rand_op(), rand_op());
      else req_valid[last_gid] = 1'b0;
    end
    if (rand_mode) begin
      for (int i = 0; i < N; i++)
        if (!req_valid[i] && $urandom_range(0, 2) == 0) load_op(i, rand_op(), rand_op());
      res_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic drain(input string tag);
    int c = 0;
    refill = '0;
    res_ready = 1'b1;
    while ((req_valid != '0 || busy) && c < 60) begin
      step();
      c++;
    end
    n_checks++;
    if (req_valid != '0 || busy || sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain_%s: req_valid=%b busy=%b pending=%0d required 0 0 0", tag, req_valid, busy, sb.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; res_ready = 1'b1;
    repeat (3) step();
    n_checks++;
    if (res_valid !== 1'b0 || res_sum !== '0 || res_id !== '0 || busy !== 1'b0 || req_ready !== '0) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b sum=%h id=%0d busy=%b ready=%b required all zero",
               res_valid, res_sum, res_id, busy, req_ready);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== '0) begin
      n_fail++;
      $display("FAIL idle_ready: req_ready=%b required=0000", req_ready);
    end
  endtask

  task automatic test_single();
    load_op(0, 40'h00_0000_0003, 40'h00_0000_0004);
    #1;
    n_checks++;
    if (req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL single_ready: req_ready=%b required=0001", req_ready);
    end
    step();
    n_checks++;
    if (res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_t1: res_valid=%b required=0", res_valid);
    end
    step();
    n_checks++;
    if (res_valid !== 1'b1 || res_sum !== 40'h7 || res_id !== 2'd0) begin
      n_fail++;
      $display("FAIL single_t2: valid=%b sum=%h id=%0d required 1 0000000007 0", res_valid, res_sum, res_id);
    end
    drain("single");
  endtask

  task automatic test_wrap();
    load_op(0, {BITS{1'b1}}, 40'h00_0000_0001);
    step(); step();
    n_checks++;
    if (res_valid !== 1'b1 || res_sum !== 40'h0 || res_id !== 2'd0) begin
      n_fail++;
      $display("FAIL wrap_one: valid=%b sum=%h id=%0d required 1 0000000000 0", res_valid, res_sum, res_id);
    end
    drain("wrap1");
    load_op(2, {BITS{1'b1}}, {BITS{1'b1}});
    step(); step();
    n_checks++;
    if (res_valid !== 1'b1 || res_sum !== 40'hFF_FFFF_FFFE || res_id !== 2'd2) begin
      n_fail++;
      $display("FAIL wrap_ones: valid=%b sum=%h id=%0d required 1 fffffffffe 2", res_valid, res_sum, res_id);
    end
    drain("wrap2");
  endtask

  task automatic test_fairness();
    int exp_id;
    rst = 1'b1;
    step();
    rst = 1'b0;
    out_ids.delete();
    refill = '1;
    for (int i = 0; i < N; i++) load_op(i, rand_op(), rand_op());
    repeat (14) step();
    n_checks++;
    if (out_ids.size() != 12) begin
      n_fail++;
      $display("FAIL fair_throughput: results=%0d required=12", out_ids.size());
    end
    for (int k = 0; k < out_ids.size(); k++) begin
`ifdef CPA_ARB_PRIO_EN
      exp_id = 0;
`else
      exp_id = k % N;
`endif
      n_checks++;
      if (out_ids[k] != exp_id) begin
        n_fail++;
        $display("FAIL fair_order[%0d]: id=%0d required=%0d", k, out_ids[k], exp_id);
      end
    end
    drain("fair");
  endtask

  task automatic test_backpressure();
    logic [BITS-1:0] held_sum;
    logic [IDW-1:0]  held_id;
    int              x0;
    res_ready = 1'b0;
    refill = '1;
    x0 = xfer_count;
    out_ids.delete();
    for (int i = 0; i < N; i++) load_op(i, rand_op(), rand_op());
    repeat (2) step();
    held_sum = res_sum;
    held_id  = res_id;
    repeat (3) step();
    n_checks++;
    if (xfer_count - x0 != 2 || req_ready !== '0 || res_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_stall: transfers=%0d ready=%b valid=%b required 2 0000 1",
               xfer_count - x0, req_ready, res_valid);
    end
    n_checks++;
    if (res_sum !== held_sum || res_id !== held_id) begin
      n_fail++;
      $display("FAIL bp_hold: sum=%h id=%0d required sum=%h id=%0d", res_sum, res_id, held_sum, held_id);
    end
    drain("bp");
    n_checks++;
    if (out_ids.size() != xfer_count - x0) begin
      n_fail++;
      $display("FAIL bp_count: results=%0d required=%0d", out_ids.size(), xfer_count - x0);
    end
  endtask

  task automatic test_reset_midflight();
    res_ready = 1'b1;
    refill = '1;
    for (int i = 0; i < N; i++) load_op(i, rand_op(), rand_op());
    repeat (3) step();
    n_checks++;
    if (res_valid !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_setup: valid=%b busy=%b required 1 1", res_valid, busy);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== '0) begin
      n_fail++;
      $display("FAIL mid_ready_rst: req_ready=%b required=0000", req_ready);
    end
    step();
    n_checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_flush: valid=%b busy=%b required 0 0", res_valid, busy);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL mid_first_grant: req_ready=%b required=0001", req_ready);
    end
    drain("mid");
  endtask

  task automatic test_sparse();
    out_ids.delete();
    load_op(2, rand_op(), rand_op());
    #1;
    n_checks++;
    if (req_ready !== 4'b0100) begin
      n_fail++;
      $display("FAIL sparse_grant2: req_ready=%b required=0100", req_ready);
    end
    repeat (4) step();
    load_op(1, rand_op(), rand_op());
    #1;
    n_checks++;
    if (req_ready !== 4'b0010) begin
      n_fail++;
      $display("FAIL sparse_grant1: req_ready=%b required=0010", req_ready);
    end
    repeat (4) step();
    n_checks++;
    if (out_ids.size() != 2 || out_ids[0] != 2 || out_ids[1] != 1) begin
      n_fail++;
      $display("FAIL sparse_ids: count=%0d first=%0d second=%0d required 2 2 1", out_ids.size(),
               (out_ids.size() > 0) ? out_ids[0] : -1, (out_ids.size() > 1) ? out_ids[1] : -1);
    end
    drain("sparse");
  endtask

  task automatic test_random_stress();
    rand_mode = 1'b1;
    refill = '0;
    repeat (300) step();
    rand_mode = 1'b0;
    drain("random");
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_fairness();
    test_backpressure();
    test_reset_midflight();
    test_sparse();
    test_random_stress();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t required finish", $time);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/cpa_share_arbiter.md
Name: cpa_share_arbiter

Overview:
Shares one combinational BITS-wide carry-propagate adder (CPA_module instance) between N_REQ requesters, e.g. multiple partial-product reduction trees in the multiplier/MAC datapath. Round-robin arbitration with a valid/ready handshake per requester. Two-stage pipeline: an operand register feeds the CPA, and a result register captures the sum. Returns sum plus requester ID with downstream backpressure.

Parameters:
BITS, 40, operand/result width passed to CPA_module
N_REQ, 4, number of requesters (2..8)
IDW, $clog2(N_REQ), requester ID width (derived; not overridden)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  N_REQ  per-requester request valid
req_ready  out  N_REQ  per-requester accept; at most one bit high (one-hot or zero)
req_a  in  N_REQ*BITS  operand A; requester i at [i*BITS +: BITS]
req_b  in  N_REQ*BITS  operand B; same packing
res_valid  out  1  result valid
res_ready  in  1  downstream accept
res_sum  out  BITS  (a+b) mod 2^BITS
res_id  out  IDW  index of the requester that produced res_sum
busy  out  1  high when either pipeline stage holds valid data

Behaviour:
- Interface (decided): one clock clk; reset rst is synchronous and active-high.
- Reset: s1_valid=0, s2_valid=0, res_valid=0, res_sum=0, res_id=0, req_ready=0, busy=0, rr_ptr=N_REQ-1 (so requester 0 wins first).
- Stage enables: s2_en = !s2_valid || res_ready; s1_en = !s1_valid || s2_en.
- Arbitration (combinational): when s1_en=1, grant the first asserted req_valid searching rr_ptr+1, rr_ptr+2, ..., wrapping modulo N_REQ. req_ready[g]=1 only for the granted index. All req_ready=0 when s1_en=0 or no req_valid is set.
- Transfer happens when req_valid[g] && req_ready[g]. On transfer: s1 captures a, b and id=g; s1_valid<=1; rr_ptr<=g. rr_ptr is unchanged when no transfer occurs.
- If s1_en=1 and there is no transfer, s1_valid<=0.
- Stage 2: when s2_en=1, s2 captures the CPA output (sum of the s1 operands) and the s1 id; s2_valid<=s1_valid.
- Latency: a transfer in cycle t gives res_valid in cycle t+2 when not back-pressured. Throughput is 1 result per cycle.
- Backpressure: if res_valid=1 and res_ready=0, res_sum and res_id hold stable. s1 holds if it is full. No data is lost or duplicated.
- Arithmetic: carry-out is discarded. Example: all-ones + 1 = 0.
- Requester rule: once req_valid is asserted, the requester holds req_valid and its operands stable until accepted. The arbiter may grant a different requester in the meantime, with no starvation: any asserted requester is granted within N_REQ transfers.
- Simultaneous events: with res_ready=1 and full stages, a new transfer, s1->s2 advance and output drain all occur in the same cycle.
- Reset asserted mid-operation: both stages are flushed next edge and in-flight results are discarded. req_ready is forced to 0 while rst=1.
- busy = s1_valid || s2_valid.

Optional Feature:
CPA_ARB_PRIO_EN
- Defined: requester 0 has absolute priority. If req_valid[0]=1 and s1_en=1, requester 0 is granted regardless of rr_ptr. rr_ptr updates only on grants to requesters 1..N_REQ-1, and the round-robin rotates among those only. Requesters 1..N_REQ-1 may starve while requester 0 is continuously valid.
- Undefined: pure round-robin across all N_REQ requesters, as described under Behaviour.

Test Plan:
- Single request: after reset, req0 a=0x00_0000_0003, b=0x00_0000_0004 -> req_ready[0]=1 in that cycle; 2 cycles later res_valid=1, res_sum=0x07, res_id=0.
- Wrap-around: a=0xFF_FFFF_FFFF, b=0x00_0000_0001 -> res_sum=0x00_0000_0000 (carry dropped).
- Round-robin fairness: all 4 requesters continuously valid, res_ready=1 -> res_id sequence 0,1,2,3,0,1,... and one result per cycle after 2-cycle fill. With CPA_ARB_PRIO_EN defined -> res_id constantly 0.
- Backpressure: res_ready=0 for 5 cycles with all requesters valid -> exactly 2 transfers accepted, then all req_ready=0, res_sum/res_id stable. When res_ready returns to 1, results drain in order with none lost.
- Reset mid-flight: rst=1 while both stages are valid -> next cycle res_valid=0, busy=0, and the first grant after reset goes to requester 0.
- Sparse requests: req2 only, then req1 only -> grants 2 then 1. rr_ptr does not move on idle cycles; check res_id=2 then 1.
